// File: rtl/ps2.sv
// PS/2 keyboard receiver: 2-flop synchronizers, clock-line debounce, 11-bit frame
// deserializer, and a 16-bit register holding the last two received bytes.
// Ports: i_clk/i_rst_n system clock and async active-low reset; i_ps2_clk/i_ps2_data
//   raw PS/2 pins (idle high); i_control sync clear of o_code; o_code {previous, latest}.
// Latency: o_code updates <= DEBOUNCE_CYCLES+4 cycles after raw clock falls for the stop bit.
module ps2 #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ps2_clk,
  input  logic        i_ps2_data,
  input  logic        i_control,
  output logic [15:0] o_code
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  // Synchronizers (idle level 1)
  logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  // Debounce
  logic            r_clk_db, r_clk_db_d;
  logic [DB_W-1:0] r_db_cnt;
  // Frame receiver
  logic [3:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_done;
  logic [TO_W-1:0] r_to_cnt;
  logic [15:0]     r_code;

  logic w_fall;
  logic w_timeout;

  assign w_fall    = r_clk_db_d & ~r_clk_db;
  assign w_timeout = (r_bit_cnt != 4'd0) && !w_fall && (r_to_cnt == TO_MAX);
  assign o_code    = r_code;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // The debounced clock only follows the synchronized clock after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_db   <= 1'b1;
      r_clk_db_d <= 1'b1;
      r_db_cnt   <= '0;
    end else begin
      r_clk_db_d <= r_clk_db;
      if (r_clk_s2 == r_clk_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_MAX) begin
        r_clk_db <= r_clk_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // Timeout runs only mid-frame and restarts on every falling edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt <= '0;
    end else if ((r_bit_cnt == 4'd0) || w_fall || (r_to_cnt == TO_MAX)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'h00;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_fall) begin
        case (r_bit_cnt)
          4'd0: begin
            // A high start bit is noise; stay idle.
            if (!r_dat_s2) r_bit_cnt <= 4'd1;
          end
          4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
          4'd9: begin
            // Parity is accepted without checking.
            r_bit_cnt <= 4'd10;
          end
          4'd10: begin
            r_done    <= r_dat_s2;
            r_bit_cnt <= 4'd0;
          end
          default: r_bit_cnt <= 4'd0;
        endcase
      end else if (w_timeout) begin
        r_bit_cnt <= 4'd0;
      end
    end
  end

  // Clear takes priority over a frame completing in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_code <= 16'h0000;
    end else if (i_control) begin
      r_code <= 16'h0000;
    end else if (r_done) begin
      r_code <= {r_code[7:0], r_shift};
    end
  end

endmodule

// File: tb/tb_ps2.sv
module tb_ps2;

  localparam int DEB = 8;
  localparam int TO  = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        control = 1'b0;
  logic [15:0] code;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: bytes accepted since the last clear/reset.
  logic [7:0] rx_q[$];

  ps2 #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_data (ps2_data),
    .i_control  (control),
    .o_code     (code)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [15:0] model_code();
    logic [15:0] c;
    int n;
    c = 16'h0000;
    n = rx_q.size();
    if (n >= 1) c[7:0]  = rx_q[n-1];
    if (n >= 2) c[15:8] = rx_q[n-2];
    return c;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sends the first nbits of a frame with a 12-cycle half-period. When the
  // stop bit is sent, the model is updated and o_code is checked exactly
  // DEB+4 cycles after the raw falling edge. clr pulses i_control in the
  // cycle the completed byte would be loaded.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int nbits, input bit clr);
    logic [10:0] fr;
    fr = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      repeat (6) tick();
      ps2_clk = 1'b0;
      for (int k = 1; k <= 12; k++) begin
        tick();
        control = (clr && i == 10 && k == DEB + 3);
      end
      control = 1'b0;
      if (i == 10) begin
        if (clr) rx_q.delete();
        else if (stp) rx_q.push_back(b);
        check("latency", code, model_code());
      end
      ps2_clk = 1'b1;
      repeat (6) tick();
    end
    ps2_data = 1'b1;
    repeat (4) tick();
  endtask

  task automatic pulse_clear();
    control = 1'b1;
    tick();
    control = 1'b0;
    rx_q.delete();
    tick();
  endtask

  initial begin
    logic [7:0] b;
    logic p, s;

    // Reset
    repeat (3) tick();
    check("reset", code, 16'h0000);
    rst_n = 1'b1;
    repeat (5) tick();
    check("post_reset_idle", code, 16'h0000);

    // Single byte, parity driven 1
    send_frame(8'h16, 1'b1, 1'b1, 11, 0);
    check("byte_16", code, 16'h0016);

    // Stop bit 0 frame is discarded
    send_frame(8'h55, 1'b0, 1'b0, 11, 0);
    check("bad_stop", code, 16'h0016);

    // Break sequence and shift
    send_frame(8'hF0, 1'b1, 1'b1, 11, 0);
    send_frame(8'h16, 1'b1, 1'b1, 11, 0);
    check("break_F016", code, 16'hF016);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 0);
    check("shift_161C", code, 16'h161C);

    // Clear pulse, then next byte
    send_frame(8'hF0, 1'b1, 1'b1, 11, 0);
    send_frame(8'h16, 1'b1, 1'b1, 11, 0);
    pulse_clear();
    check("clear", code, 16'h0000);
    send_frame(8'h2A, 1'b0, 1'b1, 11, 0);
    check("after_clear_2A", code, 16'h002A);

    // Clear in the same cycle as a frame completes: clear wins
    send_frame(8'h77, 1'b0, 1'b1, 11, 1);
    check("clear_wins", code, 16'h0000);
    send_frame(8'h3B, 1'b0, 1'b1, 11, 0);
    check("after_collision", code, 16'h003B);

    // Short low glitches on the idle clock line
    for (int g = 0; g < 3; g++) begin
      ps2_clk = 1'b0;
      repeat (3) tick();
      ps2_clk = 1'b1;
      repeat (20) tick();
    end
    check("glitch_idle", code, 16'h003B);
    send_frame(8'h16, 1'b1, 1'b1, 11, 0);
    check("glitch_then_16", code, 16'h3B16);

    // Start plus 3 data bits, then timeout
    send_frame(8'h5A, 1'b0, 1'b1, 4, 0);
    repeat (3 * TO) tick();
    check("timeout_hold", code, 16'h3B16);
    send_frame(8'h5A, 1'b0, 1'b1, 11, 0);
    check("after_timeout_5A", code, 16'h165A);

    // Reset mid-frame
    send_frame(8'hA5, 1'b0, 1'b1, 5, 0);
    rst_n = 1'b0;
    tick();
    check("reset_midframe", code, 16'h0000);
    rst_n = 1'b1;
    rx_q.delete();
    repeat (5) tick();
    send_frame(8'h81, 1'b1, 1'b1, 11, 0);
    check("after_reset_81", code, 16'h0081);

    // Randomized frames against the model
    for (int n = 0; n < 14; n++) begin
      b = 8'($urandom);
      p = 1'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send_frame(b, p, s, 11, 0);
      check("random_frame", code, model_code());
      if ($urandom_range(0, 5) == 0) begin
        pulse_clear();
        check("random_clear", code, model_code());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
